// File: rtl/capture_sequencer_if.sv
// Buffer-side bus of the capture sequencer: write and read address/enable lines.
// The sequencer drives it (master); the sample buffer consumes it (slave).
interface capture_sequencer_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    modport master (
        output mem_we,
        output mem_waddr,
        output mem_re,
        output mem_raddr
    );

    modport slave (
        input mem_we,
        input mem_waddr,
        input mem_re,
        input mem_raddr
    );
endinterface

// File: rtl/capture_sequencer.sv
// Runs one logic-analyzer capture over a circular buffer: pre-trigger fill, arm,
// trigger, post-trigger holdoff, then readout from the oldest sample to the newest.
module capture_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int USER_HOLDOFF = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   trigger,
    input  logic                   read_req,
    capture_sequencer_if.master    mem,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic                   armed,
    output logic                   triggered,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  trig_addr
);
    localparam int MEMORY_SIZE = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = ADDR_WIDTH'(MEMORY_SIZE - USER_HOLDOFF - 1);
    localparam logic [ADDR_WIDTH-1:0] POST_LAST = ADDR_WIDTH'(USER_HOLDOFF - 1);
    localparam logic [ADDR_WIDTH-1:0] RD_LAST   = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POSTTRIG,
        READOUT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] wp, rp;
    logic [ADDR_WIDTH-1:0] pre_cnt, post_cnt, rd_cnt;

    logic accept_start, accept_trig, load_rp, read_issue, read_final;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        mem.mem_we   = 1'b0;
        mem.mem_re   = 1'b0;
        accept_start = 1'b0;
        accept_trig  = 1'b0;
        load_rp      = 1'b0;
        read_issue   = 1'b0;
        read_final   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = PRETRIG;
                end
            end
            PRETRIG: begin
                mem.mem_we = 1'b1;
                if (pre_cnt == PRE_LAST) state_next = ARMED;
            end
            ARMED: begin
                mem.mem_we = 1'b1;
                if (trigger) begin
                    accept_trig = 1'b1;
                    if (USER_HOLDOFF == 0) begin
                        load_rp    = 1'b1;
                        state_next = READOUT;
                    end else begin
                        state_next = POSTTRIG;
                    end
                end
            end
            POSTTRIG: begin
                mem.mem_we = 1'b1;
                if (post_cnt == POST_LAST) begin
                    load_rp    = 1'b1;
                    state_next = READOUT;
                end
            end
            READOUT: begin
                if (read_req) begin
                    mem.mem_re = 1'b1;
                    read_issue = 1'b1;
                    if (rd_cnt == RD_LAST) begin
                        read_final = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort only redirects the next state; this cycle's write or read still completes.
        if (abort) begin
            state_next   = IDLE;
            accept_start = 1'b0;
            accept_trig  = 1'b0;
        end
    end

    assign mem.mem_waddr = wp;
    assign mem.mem_raddr = rp;
    assign armed         = (state == ARMED);
    assign done          = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            if (accept_start) begin
                wp        <= '0;
                pre_cnt   <= '0;
                triggered <= 1'b0;
            end
            if (mem.mem_we)          wp       <= wp + ADDR_ONE;
            if (state == PRETRIG)    pre_cnt  <= pre_cnt + ADDR_ONE;
            if (state == POSTTRIG)   post_cnt <= post_cnt + ADDR_ONE;
            if (accept_trig) begin
                trig_addr <= wp;
                triggered <= 1'b1;
                post_cnt  <= '0;
            end
            // The slot after the final write holds the oldest surviving sample.
            if (load_rp) begin
                rp     <= wp + ADDR_ONE;
                rd_cnt <= '0;
            end
            if (read_issue) begin
                rp     <= rp + ADDR_ONE;
                rd_cnt <= rd_cnt + ADDR_ONE;
            end
            if (abort) triggered <= 1'b0;
            rd_valid <= mem.mem_re;
            rd_last  <= read_final;
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench: two sequencers (holdoff 4 and holdoff 0) share a buffer model
// whose readout is scoreboarded against the written sample stream.
module tb_capture_sequencer;
    localparam int AW  = 4;
    localparam int MEM = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic abort;
    logic start_a, trigger_a, read_req_a;
    logic start_b, trigger_b, read_req_b;
    logic rd_valid_a, rd_last_a, armed_a, triggered_a, done_a;
    logic rd_valid_b, rd_last_b, armed_b, triggered_b, done_b;
    logic [AW-1:0] trig_addr_a, trig_addr_b;

    capture_sequencer_if #(.ADDR_WIDTH(AW)) bus_a ();
    capture_sequencer_if #(.ADDR_WIDTH(AW)) bus_b ();

    capture_sequencer #(.ADDR_WIDTH(AW), .USER_HOLDOFF(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
        .trigger(trigger_a), .read_req(read_req_a), .mem(bus_a.master),
        .rd_valid(rd_valid_a), .rd_last(rd_last_a), .armed(armed_a),
        .triggered(triggered_a), .done(done_a), .trig_addr(trig_addr_a)
    );

    capture_sequencer #(.ADDR_WIDTH(AW), .USER_HOLDOFF(0)) dut_h0 (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
        .trigger(trigger_b), .read_req(read_req_b), .mem(bus_b.master),
        .rd_valid(rd_valid_b), .rd_last(rd_last_b), .armed(armed_b),
        .triggered(triggered_b), .done(done_b), .trig_addr(trig_addr_b)
    );

    always #5 clk = ~clk;

    // Observation port follows whichever DUT the current test drives.
    logic sel;
    wire          obs_we        = sel ? bus_b.mem_we    : bus_a.mem_we;
    wire [AW-1:0] obs_waddr     = sel ? bus_b.mem_waddr : bus_a.mem_waddr;
    wire          obs_re        = sel ? bus_b.mem_re    : bus_a.mem_re;
    wire [AW-1:0] obs_raddr     = sel ? bus_b.mem_raddr : bus_a.mem_raddr;
    wire          obs_rd_valid  = sel ? rd_valid_b      : rd_valid_a;
    wire          obs_rd_last   = sel ? rd_last_b       : rd_last_a;
    wire          obs_armed     = sel ? armed_b         : armed_a;
    wire          obs_triggered = sel ? triggered_b     : triggered_a;
    wire          obs_done      = sel ? done_b          : done_a;
    wire [AW-1:0] obs_trig_addr = sel ? trig_addr_b     : trig_addr_a;

    typedef struct {
        logic [AW-1:0] addr;
        int            data;
        logic          last;
    } exp_t;

    typedef struct {
        logic          sel;
        logic          held;
        int            delay;
        int            pre_writes;
        int            post_writes;
        logic [AW-1:0] trig_addr;
        logic [AW-1:0] last_waddr;
        logic [AW-1:0] first_raddr;
    } vec_t;

    exp_t          sb_q[$];
    int            written_q[$];
    int            tb_mem[MEM];
    int            sample = 1000;
    int            wr_count, post_wr;
    logic [AW-1:0] last_waddr;
    logic [AW-1:0] rd_addr_q;
    int            rd_data_q;
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer model plus scoreboard: writes fill tb_mem, reads return one cycle later.
    always @(negedge clk) begin
        if (obs_rd_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rd_valid", obs_rd_valid, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rd_addr", rd_addr_q, e.addr);
                check("rd_data", rd_data_q, e.data);
                check("rd_last", obs_rd_last, e.last);
            end
        end else if (obs_rd_last) begin
            check("rd_last_without_valid", obs_rd_last, 0);
        end
        if (obs_re) begin
            rd_addr_q = obs_raddr;
            rd_data_q = tb_mem[obs_raddr];
        end
        if (obs_we) begin
            tb_mem[obs_waddr] = sample;
            written_q.push_back(sample);
            if (written_q.size() > MEM) void'(written_q.pop_front());
            sample++;
            wr_count++;
            last_waddr = obs_waddr;
            if (obs_triggered) post_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_trig(input logic v);
        if (sel) trigger_b = v; else trigger_a = v;
    endtask

    task automatic set_rreq(input logic v);
        if (sel) read_req_b = v; else read_req_a = v;
    endtask

    task automatic wait_armed();
        for (int i = 0; i < 100 && !obs_armed; i++) tick();
        check("armed_seen", obs_armed, 1);
    endtask

    task automatic run_to_readout(input vec_t v);
        sel = v.sel;
        tick();
        wr_count = 0;
        post_wr  = 0;
        written_q.delete();
        set_start(1'b1);
        if (v.held) set_trig(1'b1);
        tick();
        set_start(1'b0);
        wait_armed();
        check("pretrig_writes", wr_count, v.pre_writes);
        repeat (v.delay) tick();
        set_trig(1'b1);
        tick();
        check("triggered_set", obs_triggered, 1);
        if (!v.held) set_trig(1'b0);
        for (int i = 0; i < 100 && obs_we; i++) tick();
        set_trig(1'b0);
        check("we_off_in_readout", obs_we, 0);
        check("armed_off", obs_armed, 0);
        check("trig_addr", obs_trig_addr, v.trig_addr);
        check("holdoff_writes", post_wr, v.post_writes);
        check("last_waddr", last_waddr, v.last_waddr);
    endtask

    task automatic do_reads(input int n, input logic [AW-1:0] first);
        exp_t          e;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a      = first + AW'(i);
            e.addr = a;
            e.data = written_q[i];
            e.last = (i == MEM - 1);
            sb_q.push_back(e);
            set_rreq(1'b1);
            tick();
            set_rreq(1'b0);
            if (i % 3 == 1) tick();
        end
        tick();
        tick();
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{sel:1'b0, held:1'b0, delay:0,  pre_writes:12, post_writes:4,
                    trig_addr:4'd12, last_waddr:4'd0,  first_raddr:4'd1};
        vecs[1] = '{sel:1'b0, held:1'b1, delay:0,  pre_writes:12, post_writes:4,
                    trig_addr:4'd12, last_waddr:4'd0,  first_raddr:4'd1};
        vecs[2] = '{sel:1'b0, held:1'b0, delay:30, pre_writes:12, post_writes:4,
                    trig_addr:4'd10, last_waddr:4'd14, first_raddr:4'd15};
        vecs[3] = '{sel:1'b1, held:1'b0, delay:0,  pre_writes:16, post_writes:0,
                    trig_addr:4'd0,  last_waddr:4'd0,  first_raddr:4'd1};
        vecs[4] = '{sel:1'b1, held:1'b0, delay:3,  pre_writes:16, post_writes:0,
                    trig_addr:4'd3,  last_waddr:4'd3,  first_raddr:4'd4};

        sel = 1'b0;
        abort = 1'b0;
        start_a = 1'b0; trigger_a = 1'b0; read_req_a = 1'b0;
        start_b = 1'b0; trigger_b = 1'b0; read_req_b = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #20;
        check("rst_we", obs_we, 0);
        check("rst_re", obs_re, 0);
        check("rst_waddr", obs_waddr, 0);
        check("rst_raddr", obs_raddr, 0);
        check("rst_armed", obs_armed, 0);
        check("rst_triggered", obs_triggered, 0);
        check("rst_done", obs_done, 0);
        check("rst_rd_valid", obs_rd_valid, 0);
        check("rst_trig_addr", obs_trig_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Read request while idle is ignored.
        tick();
        set_rreq(1'b1);
        #1 check("re_in_idle", obs_re, 0);
        tick();
        set_rreq(1'b0);

        foreach (vecs[k]) begin
            run_to_readout(vecs[k]);
            do_reads(MEM, vecs[k].first_raddr);
            check("done_set", obs_done, 1);
            check("triggered_held", obs_triggered, 1);
            check("trig_addr_held", obs_trig_addr, vecs[k].trig_addr);
            set_rreq(1'b1);
            #1 check("re_in_done", obs_re, 0);
            tick();
            set_rreq(1'b0);
            tick();
        end

        // Abort after two holdoff writes.
        sel = 1'b0;
        tick();
        post_wr = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        wait_armed();
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_we_off", obs_we, 0);
        check("abort_triggered_clr", obs_triggered, 0);
        check("abort_armed", obs_armed, 0);
        check("abort_done", obs_done, 0);
        check("abort_holdoff_writes", post_wr, 2);
        tick();
        check("abort_stays_idle", obs_we, 0);

        // Abort beats a simultaneous start.
        abort = 1'b1;
        set_start(1'b1);
        tick();
        abort = 1'b0;
        set_start(1'b0);
        check("abort_beats_start", obs_we, 0);

        // Restart begins at address 0; a start while busy is ignored.
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("restart_we", obs_we, 1);
        check("restart_waddr", obs_waddr, 0);
        tick();
        tick();
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("busy_start_ignored", obs_waddr, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pretrig", obs_we, 0);

        // Reset during readout after five reads.
        run_to_readout(vecs[0]);
        do_reads(5, vecs[0].first_raddr);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_raddr", obs_raddr, 0);
        check("mid_rst_triggered", obs_triggered, 0);
        check("mid_rst_trig_addr", obs_trig_addr, 0);
        check("mid_rst_rd_valid", obs_rd_valid, 0);
        check("mid_rst_waddr", obs_waddr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_rreq(1'b1);
            #1 check("re_after_reset", obs_re, 0);
            tick();
            set_rreq(1'b0);
        end
        tick();
        check("no_reads_after_reset", sb_q.size(), 0);
        check("idle_after_reset", obs_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
